// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between EX/MEM and write-back
//
// Issues one load/store at a time to a multi-cycle data memory and holds the
// upstream pipeline (stall_out) until the access completes. Non-memory ops
// pass straight through to write-back. HALT and faulting accesses park the
// stage in HALTED until reset.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   *_ex                    instruction fields from the EX/MEM register
//   stall_out               hold EX/MEM (BUSY or HALTED)
//   mem_en/mem_wr/mem_addr/mem_wdata   request to data memory
//   mem_rdata/mem_done/mem_hit         response from data memory
//   *_wb                    write-back outputs (valid_wb/halt_wb/err_wb pulse)
//   mem_read_real, mem_wrt_real, dcache_req, dcache_hit   per-cycle trace strobes
//   dreq_count, dhit_count  saturating request / hit counters
module mem_stage #(
   parameter int DW   = 16,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_ex,
   input  logic            mem_read_ex,
   input  logic            mem_wrt_ex,
   input  logic            halt_ex,
   input  logic            reg_wrt_ex,
   input  logic [2:0]      target_reg_ex,
   input  logic [DW-1:0]   addr_ex,
   input  logic [DW-1:0]   wdata_ex,
   output logic            stall_out,
   output logic            mem_en,
   output logic            mem_wr,
   output logic [DW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_done,
   input  logic            mem_hit,
   output logic            valid_wb,
   output logic            reg_wrt_wb,
   output logic [2:0]      target_reg_wb,
   output logic [DW-1:0]   wb_data,
   output logic            halt_wb,
   output logic            err_wb,
   output logic            mem_read_real,
   output logic            mem_wrt_real,
   output logic            dcache_req,
   output logic            dcache_hit,
   output logic [CNTW-1:0] dreq_count,
   output logic [CNTW-1:0] dhit_count
);

   typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   state_t     state;
   logic       op_load;
   logic       cap_reg_wrt;
   logic [2:0] cap_target;
   logic       is_mem;
   logic       fault;

   always_comb begin
      is_mem = mem_read_ex | mem_wrt_ex;
      fault  = (is_mem & addr_ex[0]) | (mem_read_ex & mem_wrt_ex);
   end

   // Pure state decode: no path from mem_done, so it can't form a loop
   // through the upstream stall logic.
   assign stall_out     = (state == BUSY) | (state == HALTED);
   assign mem_read_real = mem_en & ~mem_wr;
   assign mem_wrt_real  = mem_en & mem_wr;
   assign dcache_req    = mem_en;
   assign dcache_hit    = mem_en & mem_done & mem_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         mem_en        <= 1'b0;
         mem_wr        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         valid_wb      <= 1'b0;
         reg_wrt_wb    <= 1'b0;
         target_reg_wb <= '0;
         wb_data       <= '0;
         halt_wb       <= 1'b0;
         err_wb        <= 1'b0;
         op_load       <= 1'b0;
         cap_reg_wrt   <= 1'b0;
         cap_target    <= '0;
         dreq_count    <= '0;
         dhit_count    <= '0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         mem_en     <= 1'b0;
         valid_wb   <= 1'b0;
         reg_wrt_wb <= 1'b0;
         halt_wb    <= 1'b0;
         err_wb     <= 1'b0;

         if (mem_en && dreq_count != CNT_MAX)
            dreq_count <= dreq_count + 1'b1;
         if (dcache_hit && dhit_count != CNT_MAX)
            dhit_count <= dhit_count + 1'b1;

         case (state)
            IDLE: begin
               if (valid_ex) begin
                  if (halt_ex) begin
                     // Memory bits on a HALT are deliberately ignored.
                     valid_wb      <= 1'b1;
                     halt_wb       <= 1'b1;
                     target_reg_wb <= target_reg_ex;
                     state         <= HALTED;
                  end else if (fault) begin
                     valid_wb      <= 1'b1;
                     err_wb        <= 1'b1;
                     target_reg_wb <= target_reg_ex;
                     state         <= HALTED;
                  end else if (is_mem) begin
                     mem_en      <= 1'b1;
                     mem_wr      <= mem_wrt_ex;
                     mem_addr    <= addr_ex;
                     mem_wdata   <= wdata_ex;
                     op_load     <= mem_read_ex;
                     cap_reg_wrt <= reg_wrt_ex;
                     cap_target  <= target_reg_ex;
                     state       <= BUSY;
                  end else begin
                     valid_wb      <= 1'b1;
                     reg_wrt_wb    <= reg_wrt_ex;
                     target_reg_wb <= target_reg_ex;
                     wb_data       <= addr_ex;
                  end
               end
            end
            BUSY: begin
               if (mem_done) begin
                  valid_wb      <= 1'b1;
                  reg_wrt_wb    <= cap_reg_wrt;
                  target_reg_wb <= cap_target;
                  wb_data       <= op_load ? mem_rdata : mem_addr;
                  state         <= IDLE;
               end
            end
            HALTED: begin
               // Only reset leaves this state.
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
